dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk in 1 (rising-edge clock); rst in 1 (synchronous, active-high reset).
REQ-002 SHALL have these ports, listed as name, direction, width, meaning:
- mem_valid in 1: MEM stage holds a valid instruction.
- mem_addr in 32: effective address.
- mem_wdata in 32: lane-aligned store data.
- mem_wen in 4: byte write enables; 0000 means no store.
- mem_load in 1: instruction is a load.
- mem_ld_size in 2: 00 word, 01 half, 10 byte.
- mem_ld_unsigned in 1: zero-extend the load result.
- mem_except in 1: exception already flagged for this instruction; suppress the access.
- flush in 1: pipeline flush.
- data_req out 1, data_wr out 1, data_size out 2, data_addr out 32, data_wdata out 32, data_wstrb out 4: SRAM-like request channel.
- data_addr_ok in 1: request accepted.
- data_data_ok in 1: response or write-done.
- data_rdata in 32: read data.
- mem_stall out 1: freeze IF..MEM stages.
- wb_rdata out 32: extended load result.
- wb_rdata_valid out 1: wb_rdata is valid this cycle.

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, DATA, HOLD.
REQ-004 SHALL treat start = mem_valid & ~mem_except & ~flush & (mem_load | mem_wen != 0).
- In IDLE with start true: latch addr, wdata, wen, ld_size, ld_unsigned, and write flag (mem_wen != 0); go to ADDR.
REQ-005 SHALL assert data_req only in ADDR, driving the latched values, all stable until data_addr_ok is sampled high; then go to DATA.
REQ-006 SHALL drive data_addr with bits [1:0] forced to 00 for stores and kept exact for loads.
- data_wstrb SHALL equal the latched wen; for loads data_wstrb SHALL be 0000.
REQ-007 SHALL derive data_size as follows:
- Stores: 1111 gives 2; 0011 or 1100 gives 1; single-bit strobe gives 0.
- Loads: ld_size 00/01/10 gives 2/1/0.
REQ-008 SHALL, in DATA, wait for data_data_ok, then go to HOLD.
- On that edge, a load SHALL register the extended data_rdata into wb_rdata.
REQ-009 SHALL, in HOLD, deassert mem_stall for exactly one cycle, pulse wb_rdata_valid for loads, then return to IDLE.
REQ-010 SHALL compute mem_stall combinationally as (IDLE & start) | ADDR | DATA, giving a one-cycle access minimum latency of 3 stalled cycles.
REQ-011 SHALL extend loads as follows, using the latched addr[1:0]:
- Byte: select data_rdata[8*a+7:8*a].
- Half: select data_rdata[31:16] if addr[1] is 1, else data_rdata[15:0].
- Extension is sign or zero per ld_unsigned.
REQ-012 SHALL never withdraw a request once data_req is high.
- A flush in ADDR or DATA SHALL set a cancel flag, and the transaction SHALL complete normally.
- On data_data_ok with the cancel flag set, the FSM SHALL go to IDLE instead of HOLD.
- wb_rdata SHALL be left unchanged, wb_rdata_valid SHALL stay 0, and the cancel flag SHALL clear.
REQ-013 SHALL ignore a flush or mem_except in IDLE: no request is issued and mem_stall stays 0.
REQ-014 SHALL accept data_addr_ok and data_data_ok in the same cycle and still pass through DATA for one cycle.
- data_data_ok arriving outside DATA SHALL be ignored.
REQ-015 SHALL treat mem_load together with mem_wen != 0 as a store, with write priority.

Reset
REQ-016 SHALL, on rst high at a clock edge, set the state to IDLE and clear the cancel flag.
- It SHALL zero wb_rdata, wb_rdata_valid, and all latched request fields, giving data_req=0 and mem_stall=0 the following cycle.
REQ-017 SHALL abandon any in-flight transaction on reset; late data_addr_ok or data_data_ok pulses SHALL then be ignored.

Structure
REQ-018 SHALL place the FSM state enum, the data_size constants (SIZE_B=0, SIZE_H=1, SIZE_W=2), and the ld_size encodings in the shared CPU package.
REQ-019 SHALL implement load extension as a combinational sub-module named load_ext (inputs: rdata, addr[1:0], size, unsigned; output: 32-bit result).

Verification
REQ-020 Word store: addr=0x80000104, wen=1111, wdata=0xDEADBEEF, addr_ok after 2 cycles, data_ok 1 cycle later.
- Required: data_req held 2 cycles, data_size=2, wstrb=1111, mem_stall high 4 cycles, then low in HOLD.
REQ-021 Byte load, signed: addr[1:0]=11, rdata=0x80FF0012.
- Required: wb_rdata=0xFFFFFF80 with wb_rdata_valid pulsed once; unsigned gives 0x00000080.
REQ-022 Half load: addr[1:0]=10, rdata=0x7FFF8000, ld_unsigned=0.
- Required: wb_rdata=0x00007FFF; with addr[1:0]=00, wb_rdata=0xFFFF8000.
REQ-023 Flush in ADDR, load pending.
- Required: data_req stays high until addr_ok, transaction completes, FSM returns to IDLE, wb_rdata_valid stays 0, wb_rdata unchanged.
REQ-024 Reset asserted in DATA.
- Required: the next cycle is IDLE with data_req=0, mem_stall=0, wb_rdata=0, and a following data_data_ok is ignored.
REQ-025 mem_except=1 with wen=1111.
- Required: no data_req and mem_stall=0 throughout.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared types and encodings for the data-memory bridge
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // data_size encodings on the SRAM-like channel
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // ld_size encodings from the MEM stage
  localparam logic [1:0] LD_W = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_B = 2'b10;

  // Access size: stores derive it from the strobe pattern, loads from ld_size
  function automatic logic [1:0] req_size(input logic wr, input logic [3:0] wen,
                                          input logic [1:0] ld_size);
    logic [1:0] sz;
    if (wr) begin
      case (wen)
        4'b1111:         sz = SIZE_W;
        4'b0011, 4'b1100: sz = SIZE_H;
        default:         sz = SIZE_B;
      endcase
    end else begin
      case (ld_size)
        LD_H:    sz = SIZE_H;
        LD_B:    sz = SIZE_B;
        default: sz = SIZE_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// rtl/dmem_bridge_if.sv - SRAM-like data request/response channel
interface dmem_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_bridge_load_ext.sv
// rtl/dmem_bridge_load_ext.sv - lane select and sign/zero extension of load data
module load_ext
  import dmem_bridge_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend it to 32 bits
  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      LD_B:    result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      LD_H:    result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - MEM-stage to SRAM-like data bus bridge with stall control
module dmem_bridge
  import dmem_bridge_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wen,
  input  logic          mem_load,
  input  logic [1:0]    mem_ld_size,
  input  logic          mem_ld_unsigned,
  input  logic          mem_except,
  input  logic          flush,
  dmem_bridge_if.master bus,
  output logic          mem_stall,
  output logic [31:0]   wb_rdata,
  output logic          wb_rdata_valid
);

  state_e      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] addr_q, wdata_q, wb_rdata_q, ext_data;
  logic [3:0]  wen_q;
  logic [1:0]  ld_size_q;
  logic        ld_uns_q, wr_q;
  logic        start, latch_req, capture;

  // A store wins over a load when both are flagged
  assign start = mem_valid & ~mem_except & ~flush & (mem_load | (mem_wen != 4'b0000));

  load_ext u_load_ext (
    .rdata_i    (bus.data_rdata),
    .addr_i     (addr_q[1:0]),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .result_o   (ext_data)
  );

  // State, cancel flag, latched request and load result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cancel_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= '0;
      ld_size_q  <= '0;
      ld_uns_q   <= 1'b0;
      wr_q       <= 1'b0;
      wb_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      if (latch_req) begin
        addr_q    <= mem_addr;
        wdata_q   <= mem_wdata;
        wen_q     <= mem_wen;
        ld_size_q <= mem_ld_size;
        ld_uns_q  <= mem_ld_unsigned;
        wr_q      <= (mem_wen != 4'b0000);
      end
      if (capture) wb_rdata_q <= ext_data;
    end
  end

  // Next state; a flushed transaction still runs to completion but skips HOLD
  always_comb begin
    state_d   = state_q;
    cancel_d  = cancel_q;
    latch_req = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch_req = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (flush) cancel_d = 1'b1;
        if (bus.data_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bus.data_data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q | flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            capture = ~wr_q;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and pipeline-facing outputs
  always_comb begin
    bus.data_req   = (state_q == ST_ADDR);
    bus.data_wr    = wr_q;
    bus.data_size  = req_size(wr_q, wen_q, ld_size_q);
    bus.data_addr  = wr_q ? {addr_q[31:2], 2'b00} : addr_q;
    bus.data_wdata = wdata_q;
    bus.data_wstrb = wr_q ? wen_q : 4'b0000;
    mem_stall      = ((state_q == ST_IDLE) & start) | (state_q == ST_ADDR) | (state_q == ST_DATA);
    wb_rdata_valid = (state_q == ST_HOLD) & ~wr_q;
    wb_rdata       = wb_rdata_q;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_load, mem_ld_unsigned, mem_except, flush;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_ld_size;
  logic        mem_stall, wb_rdata_valid;
  logic [31:0] wb_rdata;
  int          checks = 0;
  int          errors = 0;

  dmem_bridge_if bus ();

  dmem_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .mem_valid       (mem_valid),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wen         (mem_wen),
    .mem_load        (mem_load),
    .mem_ld_size     (mem_ld_size),
    .mem_ld_unsigned (mem_ld_unsigned),
    .mem_except      (mem_except),
    .flush           (flush),
    .bus             (bus.master),
    .mem_stall       (mem_stall),
    .wb_rdata        (wb_rdata),
    .wb_rdata_valid  (wb_rdata_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access from IDLE: addr_ok after wait_n ADDR cycles, data_ok the next cycle
  task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wen, input logic ld, input logic [1:0] lsz,
                        input logic uns, input logic [31:0] rdata, input int wait_n,
                        input logic [31:0] exp_addr, input logic [1:0] exp_size,
                        input logic [3:0] exp_strb, input logic exp_valid);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wen = wen;
    mem_load = ld; mem_ld_size = lsz; mem_ld_unsigned = uns;
    #1;
    chk({tag, " idle_stall"}, 32'(mem_stall), 32'd1);
    chk({tag, " idle_req"}, 32'(bus.data_req), 32'd0);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      mem_valid = 1'b0;
      bus.data_addr_ok = (i == wait_n - 1);
      #1;
      chk({tag, " req"}, 32'(bus.data_req), 32'd1);
      chk({tag, " addr_stall"}, 32'(mem_stall), 32'd1);
      if (i == 0) begin
        chk({tag, " addr"}, bus.data_addr, exp_addr);
        chk({tag, " size"}, 32'(bus.data_size), 32'(exp_size));
        chk({tag, " wstrb"}, 32'(bus.data_wstrb), 32'(exp_strb));
        chk({tag, " wr"}, 32'(bus.data_wr), 32'(wen != 4'b0000));
        if (wen != 4'b0000) chk({tag, " wdata"}, bus.data_wdata, wdata);
      end
    end
    @(negedge clk);
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
    #1;
    chk({tag, " data_req"}, 32'(bus.data_req), 32'd0);
    chk({tag, " data_stall"}, 32'(mem_stall), 32'd1);
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    #1;
    chk({tag, " hold_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, " hold_valid"}, 32'(wb_rdata_valid), 32'(exp_valid));
    @(negedge clk);
    #1;
    chk({tag, " after_valid"}, 32'(wb_rdata_valid), 32'd0);
    chk({tag, " after_stall"}, 32'(mem_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wen = '0;
    mem_load = 1'b0; mem_ld_size = 2'b00; mem_ld_unsigned = 1'b0;
    mem_except = 1'b0; flush = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset req", 32'(bus.data_req), 32'd0);
    chk("reset stall", 32'(mem_stall), 32'd0);
    chk("reset wb_rdata", wb_rdata, 32'h0);
    chk("reset valid", 32'(wb_rdata_valid), 32'd0);

    // Word store, addr_ok after 2 cycles
    access("sw", 32'h8000_0104, 32'hDEAD_BEEF, 4'b1111, 1'b0, 2'b00, 1'b0, 32'h0, 2,
           32'h8000_0104, 2'd2, 4'b1111, 1'b0);
    // Byte store on an unaligned address: address lanes forced to 00
    access("sb", 32'h8000_0107, 32'h1100_0000, 4'b1000, 1'b0, 2'b00, 1'b0, 32'h0, 1,
           32'h8000_0104, 2'd0, 4'b1000, 1'b0);
    // Load flagged together with strobes behaves as a half store
    access("ld_st", 32'h8000_0012, 32'h5555_0000, 4'b1100, 1'b1, 2'b01, 1'b0, 32'h0, 1,
           32'h8000_0010, 2'd1, 4'b1100, 1'b0);

    // Signed and unsigned byte loads from lane 3
    access("lb", 32'h8000_0203, 32'h0, 4'b0000, 1'b1, 2'b10, 1'b0, 32'h80FF_0012, 1,
           32'h8000_0203, 2'd0, 4'b0000, 1'b1);
    chk("lb wb_rdata", wb_rdata, 32'hFFFF_FF80);
    access("lbu", 32'h8000_0203, 32'h0, 4'b0000, 1'b1, 2'b10, 1'b1, 32'h80FF_0012, 2,
           32'h8000_0203, 2'd0, 4'b0000, 1'b1);
    chk("lbu wb_rdata", wb_rdata, 32'h0000_0080);

    // Signed half loads from both halves
    access("lh_hi", 32'h8000_0302, 32'h0, 4'b0000, 1'b1, 2'b01, 1'b0, 32'h7FFF_8000, 1,
           32'h8000_0302, 2'd1, 4'b0000, 1'b1);
    chk("lh_hi wb_rdata", wb_rdata, 32'h0000_7FFF);
    access("lh_lo", 32'h8000_0300, 32'h0, 4'b0000, 1'b1, 2'b01, 1'b0, 32'h7FFF_8000, 1,
           32'h8000_0300, 2'd1, 4'b0000, 1'b1);
    chk("lh_lo wb_rdata", wb_rdata, 32'hFFFF_8000);

    // Word load
    access("lw", 32'h8000_0400, 32'h0, 4'b0000, 1'b1, 2'b00, 1'b0, 32'hCAFE_F00D, 1,
           32'h8000_0400, 2'd2, 4'b0000, 1'b1);
    chk("lw wb_rdata", wb_rdata, 32'hCAFE_F00D);

    // Flush while the load sits in ADDR: request held, result discarded
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h8000_0500; mem_wen = 4'b0000; mem_load = 1'b1;
    mem_ld_size = 2'b00; mem_ld_unsigned = 1'b0;
    @(negedge clk);
    mem_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl req1", 32'(bus.data_req), 32'd1);
    @(negedge clk);
    flush = 1'b0; bus.data_addr_ok = 1'b1;
    #1;
    chk("fl req2", 32'(bus.data_req), 32'd1);
    @(negedge clk);
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
    #1;
    chk("fl data_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    #1;
    chk("fl valid", 32'(wb_rdata_valid), 32'd0);
    chk("fl stall", 32'(mem_stall), 32'd0);
    chk("fl req_idle", 32'(bus.data_req), 32'd0);
    chk("fl wb_rdata", wb_rdata, 32'hCAFE_F00D);

    // Reset while in DATA, then a stray data_ok
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h8000_0600; mem_load = 1'b1; mem_wen = 4'b0000;
    @(negedge clk);
    mem_valid = 1'b0; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    #1;
    chk("rst pre_stall", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst req", 32'(bus.data_req), 32'd0);
    chk("rst stall", 32'(mem_stall), 32'd0);
    chk("rst wb_rdata", wb_rdata, 32'h0);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    #1;
    chk("rst late valid", 32'(wb_rdata_valid), 32'd0);
    chk("rst late wb", wb_rdata, 32'h0);
    chk("rst late req", 32'(bus.data_req), 32'd0);

    // Exception and flush in IDLE suppress the access
    @(negedge clk);
    mem_valid = 1'b1; mem_except = 1'b1; mem_wen = 4'b1111; mem_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("exc req", 32'(bus.data_req), 32'd0);
      chk("exc stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
    end
    mem_except = 1'b0; flush = 1'b1; mem_wen = 4'b0000; mem_load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("flidle req", 32'(bus.data_req), 32'd0);
      chk("flidle stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
    end
    mem_valid = 1'b0; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
